score_link_ctl: RTL and testbench

SCORE_LINK_CTL -- requirements
Module: score_link_ctl

---
 rtl/score_link_ctl.sv | 146 ++++++++++++++
 tb/tb_score_link_ctl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_link_ctl.sv
// Score broadcaster: sends {sync, points, board_ID} over two UART links in turn.
// Define SCORE_LINK_CHECKSUM_EN to append an XOR checksum byte to each packet.
module score_link_ctl #(
    parameter int         REFRESH_FRAMES = 60,
    parameter int         STALL_LIMIT    = 1024,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [7:0]  board_ID,
    input  logic [23:0] points,
    input  logic        tx_full_1,
    input  logic        tx_full_2,
    output logic [7:0]  tx_byte,
    output logic        wr_en_1,
    output logic        wr_en_2,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int RW = (REFRESH_FRAMES > 1) ? $clog2(REFRESH_FRAMES) : 1;
    localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
`ifdef SCORE_LINK_CHECKSUM_EN
    localparam logic [2:0] LAST = 3'd5;
`else
    localparam logic [2:0] LAST = 3'd4;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        NEXT
    } state_t;

    state_t         state;
    logic [31:0]    snap;
    logic           pending;
    logic [RW-1:0]  rcnt;
    logic           link;
    logic [2:0]     idx;
    logic [SW-1:0]  stall;
    logic [7:0]     cur_byte;

    logic refresh_hit;
    logic changed;
    logic start;
    logic sel_full;

    assign refresh_hit = frame_tick && (rcnt == RW'(REFRESH_FRAMES - 1));
    assign changed     = ({points, board_ID} != snap);
    assign start       = (state == IDLE) && pending && (board_ID != 8'd0);
    assign sel_full    = link ? tx_full_2 : tx_full_1;

    always_comb begin
        cur_byte = SYNC_BYTE;
        unique case (idx)
            3'd1:    cur_byte = snap[31:24];
            3'd2:    cur_byte = snap[23:16];
            3'd3:    cur_byte = snap[15:8];
            3'd4:    cur_byte = snap[7:0];
`ifdef SCORE_LINK_CHECKSUM_EN
            3'd5:    cur_byte = snap[31:24] ^ snap[23:16]
                              ^ snap[15:8] ^ snap[7:0];
`endif
            default: cur_byte = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state    <= IDLE;
            snap     <= '0;
            pending  <= 1'b0;
            rcnt     <= '0;
            link     <= 1'b0;
            idx      <= '0;
            stall    <= '0;
            tx_byte  <= '0;
            wr_en_1  <= 1'b0;
            wr_en_2  <= 1'b0;
            busy     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            wr_en_1 <= 1'b0;
            wr_en_2 <= 1'b0;

            if (frame_tick)
                rcnt <= refresh_hit ? '0 : rcnt + RW'(1);

            // The packet being started already carries any refresh request
            if (start)
                pending <= 1'b0;
            else if (changed || refresh_hit)
                pending <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        snap  <= {points, board_ID};
                        link  <= 1'b0;
                        idx   <= '0;
                        stall <= '0;
                        busy  <= 1'b1;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (!sel_full) begin
                        tx_byte <= cur_byte;
                        wr_en_1 <= !link;
                        wr_en_2 <= link;
                        stall   <= '0;
                        // NEXT never samples tx_full, so it doubles as the gap
                        state   <= (idx == LAST) ? NEXT : GAP;
                    end else if (stall == SW'(STALL_LIMIT - 1)) begin
                        if (drop_cnt != 8'hFF)
                            drop_cnt <= drop_cnt + 8'd1;
                        stall <= '0;
                        state <= NEXT;
                    end else begin
                        stall <= stall + SW'(1);
                    end
                end
                GAP: begin
                    idx   <= idx + 3'd1;
                    state <= SEND;
                end
                NEXT: begin
                    stall <= '0;
                    idx   <= '0;
                    if (!link) begin
                        link  <= 1'b1;
                        state <= SEND;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_link_ctl.sv
// Randomized scoreboard bench for score_link_ctl with a packet-level reference model.
module tb_score_link_ctl;

    localparam int RF = 3;
    localparam int SL = 16;
`ifdef SCORE_LINK_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic [7:0]  board_ID = 8'd0;
    logic [23:0] points = 24'd0;
    logic        tx_full_1 = 1'b0;
    logic        tx_full_2 = 1'b0;
    logic [7:0]  tx_byte;
    logic        wr_en_1;
    logic        wr_en_2;
    logic        busy;
    logic [7:0]  drop_cnt;

    always #5 pclk = ~pclk;

    score_link_ctl #(
        .REFRESH_FRAMES(RF),
        .STALL_LIMIT(SL),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .pclk(pclk),
        .rst(rst),
        .frame_tick(frame_tick),
        .board_ID(board_ID),
        .points(points),
        .tx_full_1(tx_full_1),
        .tx_full_2(tx_full_2),
        .tx_byte(tx_byte),
        .wr_en_1(wr_en_1),
        .wr_en_2(wr_en_2),
        .busy(busy),
        .drop_cnt(drop_cnt)
    );

    typedef struct {
        int         cyc;
        bit         link;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;

    int compared = 0;
    int mismatched = 0;

    // Reference model state, stepped once per cycle at the falling edge
    int          cyc = 0;
    int          busy_until = -1;
    int          drop_at = -1;
    int          last_start = -1000;
    int          drop_m = 0;
    int          rc = 0;
    bit          pending_m = 0;
    bit          rst_seen = 0;
    bit          hit;
    logic [31:0] snap_m = '0;
    logic [31:0] cur;
    logic [7:0]  pk[NB];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    always @(negedge pclk) begin
        cyc++;
        if (cyc == drop_at)
            drop_m = (drop_m == 255) ? 255 : drop_m + 1;

        check("busy", {31'd0, busy}, (cyc <= busy_until) ? 1 : 0);
        check("drop_cnt", {24'd0, drop_cnt}, drop_m);
        check("wr_exclusive", {31'd0, wr_en_1 & wr_en_2}, 0);
        if (rst_seen) begin
            check("rst_tx_byte", {24'd0, tx_byte}, 0);
            check("rst_wr_en", {30'd0, wr_en_2, wr_en_1}, 0);
        end

        if (wr_en_1 || wr_en_2) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {30'd0, wr_en_2, wr_en_1}, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_link2", {31'd0, wr_en_2}, {31'd0, e.link});
                check("wr_byte", {24'd0, tx_byte}, {24'd0, e.data});
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check("missed_write", {30'd0, wr_en_2, wr_en_1},
                  e.link ? 2 : 1);
        end

        rst_seen = rst;
        if (rst) begin
            pending_m  = 0;
            rc         = 0;
            snap_m     = '0;
            busy_until = cyc;
            drop_at    = -1;
            drop_m     = 0;
            exp_q.delete();
        end else begin
            cur = {points, board_ID};
            hit = frame_tick && (rc == RF - 1);
            if (cyc > busy_until && pending_m && board_ID != 8'd0) begin
                pk[0] = 8'hA5;
                pk[1] = points[23:16];
                pk[2] = points[15:8];
                pk[3] = points[7:0];
                pk[4] = board_ID;
`ifdef SCORE_LINK_CHECKSUM_EN
                pk[5] = pk[1] ^ pk[2] ^ pk[3] ^ pk[4];
`endif
                for (int k = 0; k < NB; k++)
                    exp_q.push_back('{cyc + 2 + 2 * k, 1'b0, pk[k]});
                if (!tx_full_2) begin
                    for (int k = 0; k < NB; k++)
                        exp_q.push_back('{cyc + 2 * NB + 2 + 2 * k, 1'b1, pk[k]});
                    busy_until = cyc + 4 * NB;
                end else begin
                    drop_at    = cyc + 2 * NB + SL + 1;
                    busy_until = drop_at;
                end
                snap_m     = cur;
                pending_m  = 0;
                last_start = cyc;
            end else if (cur != snap_m || hit) begin
                pending_m = 1;
            end
            if (frame_tick)
                rc = hit ? 0 : rc + 1;
        end
    end

    task automatic step_quiet();
        @(posedge pclk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic step_random();
        @(posedge pclk);
        #1;
        frame_tick = !frame_tick && ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 39) == 0)
            points = 24'($urandom);
        if ($urandom_range(0, 59) == 0)
            board_ID = 8'($urandom_range(0, 3));
    endtask

    task automatic drain();
        board_ID = 8'd0;
        for (int i = 0; i < 100; i++) begin
            step_quiet();
            if (cyc > busy_until + 2)
                break;
        end
        check("drain_busy", {31'd0, busy}, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step_quiet();
        rst      = 1'b0;
        board_ID = 8'h01;
        points   = 24'h000120;
        repeat (8) step_quiet();
        points = 24'h000130;
        repeat (60) step_quiet();
        repeat (12) step_quiet();
        frame_tick = 1'b1;
        points     = 24'h000999;
        repeat (60) step_quiet();

        repeat (1500) step_random();
        drain();

        tx_full_2 = 1'b1;
        board_ID  = 8'h02;
        repeat (1000) step_random();
        drain();
        tx_full_2 = 1'b0;

        board_ID = 8'h02;
        points   = 24'h123456;
        repeat (40) step_quiet();
        board_ID = 8'h03;
        for (int i = 0; i < 100; i++) begin
            step_quiet();
            if (busy_until >= cyc && cyc - last_start >= 4)
                break;
        end
        check("reset_window_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        step_quiet();
        rst = 1'b0;
        repeat (10) step_quiet();

        repeat (500) step_random();
        drain();
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
